dm_encode_ctrl: RTL and testbench

Sequencing controller for the delta-modulation encoder path. It accepts 8-bit samples over a valid/ready handshake and holds each one for a fixed number of bit periods. On each bit-rate tick it emits one delta-modulation bit and keeps the running estimate and step size, optionally adapting the step. It sits between the sample source and the serial output stage, and owns encoder pacing, step control and estimate bookkeeping.

---
 rtl/dm_encode_ctrl_if.sv | 11 +
 rtl/dm_encode_ctrl.sv | 140 ++++++++++++++
 tb/tb_dm_encode_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_encode_ctrl_if.sv
// Sample handshake bundle between the sample source (master) and dm_encode_ctrl (slave).
interface dm_encode_ctrl_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;

    modport master (output s_data, s_valid, input s_ready);
    modport slave  (input s_data, s_valid, output s_ready);
endinterface

// File: rtl/dm_encode_ctrl.sv
// Delta-modulation encoder sequencer: paces bits per sample, tracks estimate and step.
// Define DM_ADAPT_EN for run-length step adaptation; otherwise the step stays at its loaded value.
module dm_encode_ctrl #(
    parameter int DATA_W          = 8,
    parameter int ACC_W           = 14,
    parameter int BITS_PER_SAMPLE = 8,
    parameter int STEP_MIN        = 1,
    parameter int STEP_MAX        = 64,
    parameter int RUN_LEN         = 3
) (
    input  logic              CLK100MHZ,
    input  logic              CPU_RESETN,
    input  logic              clear,
    input  logic [7:0]        step_init,
    input  logic              tick,
    dm_encode_ctrl_if.slave   s,
    output logic              bit_out,
    output logic              bit_valid,
    output logic              busy,
    output logic [7:0]        step_cur,
    output logic [ACC_W-1:0]  est
);
    localparam int CNT_W = $clog2(BITS_PER_SAMPLE + 1);

    generate
        if (STEP_MAX > 255 || STEP_MIN > STEP_MAX || RUN_LEN < 2 || DATA_W > ACC_W) begin : g_bad_cfg
            $error("dm_encode_ctrl: invalid parameter set");
        end
    endgenerate

    typedef enum logic {IDLE, ENCODE} state_t;
    state_t state;

    logic [ACC_W-1:0] sample;
    logic [CNT_W-1:0] bit_cnt;
    logic             enc_bit;
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] est_nxt;
    logic [7:0]       step_nxt;
    logic             bit_fire;

    assign bit_fire = (state == ENCODE) && tick && !clear;

    // One extra sum bit catches overflow so the estimate saturates instead of wrapping.
    always_comb begin
        enc_bit = (sample >= est);
        sum     = {1'b0, est} + (ACC_W+1)'(step_cur);
        if (enc_bit)
            est_nxt = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
        else
            est_nxt = (est >= ACC_W'(step_cur)) ? est - ACC_W'(step_cur) : '0;
    end

`ifdef DM_ADAPT_EN
    localparam int RUN_W = $clog2(RUN_LEN + 1);

    logic [RUN_LEN-2:0] hist;
    logic [RUN_W-1:0]   run_cnt;
    logic [RUN_LEN-1:0] window;
    logic [8:0]         step_dbl;

    // run_cnt saturates at RUN_LEN; it only gates when enough bits exist to judge a run.
    always_comb begin
        window   = {hist, enc_bit};
        step_dbl = {step_cur, 1'b0};
        step_nxt = step_cur;
        if (run_cnt >= RUN_W'(RUN_LEN - 1) && (window == '0 || window == '1))
            step_nxt = (step_dbl > 9'(STEP_MAX)) ? 8'(STEP_MAX) : step_dbl[7:0];
        else if (run_cnt != '0 && hist[0] != enc_bit)
            step_nxt = ((step_cur >> 1) < 8'(STEP_MIN)) ? 8'(STEP_MIN) : (step_cur >> 1);
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            hist    <= '0;
            run_cnt <= '0;
        end else if (clear) begin
            hist    <= '0;
            run_cnt <= '0;
        end else if (bit_fire) begin
            hist <= window[RUN_LEN-2:0];
            if (run_cnt != RUN_W'(RUN_LEN))
                run_cnt <= run_cnt + RUN_W'(1);
        end
    end
`else
    assign step_nxt = step_cur;
`endif

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state     <= IDLE;
            s.s_ready <= 1'b1;
            busy      <= 1'b0;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            step_cur  <= 8'(STEP_MIN);
            est       <= '0;
            sample    <= '0;
            bit_cnt   <= '0;
        end else begin
            bit_valid <= 1'b0;
            if (clear) begin
                state     <= IDLE;
                s.s_ready <= 1'b1;
                busy      <= 1'b0;
                est       <= '0;
                step_cur  <= step_init;
                bit_cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (s.s_valid) begin
                            sample    <= ACC_W'(s.s_data);
                            bit_cnt   <= CNT_W'(BITS_PER_SAMPLE);
                            state     <= ENCODE;
                            s.s_ready <= 1'b0;
                            busy      <= 1'b1;
                        end
                    end
                    ENCODE: begin
                        if (tick) begin
                            bit_out   <= enc_bit;
                            bit_valid <= 1'b1;
                            est       <= est_nxt;
                            step_cur  <= step_nxt;
                            bit_cnt   <= bit_cnt - CNT_W'(1);
                            if (bit_cnt == CNT_W'(1)) begin
                                state     <= IDLE;
                                s.s_ready <= 1'b1;
                                busy      <= 1'b0;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_dm_encode_ctrl.sv
// Self-checking bench for dm_encode_ctrl against a queue-based delta-modulation model.
module tb_dm_encode_ctrl;
    localparam int ACC_W    = 14;
    localparam int NBITS    = 8;
    localparam int STEP_MIN = 1;
    localparam int STEP_MAX = 64;
    localparam int RUN_LEN  = 3;

    logic             CLK100MHZ = 1'b0;
    logic             CPU_RESETN = 1'b0;
    logic             clear = 1'b0;
    logic             tick = 1'b0;
    logic [7:0]       step_init = '0;
    logic             bit_out, bit_valid, busy;
    logic [7:0]       step_cur;
    logic [ACC_W-1:0] est;

    dm_encode_ctrl_if #(.DATA_W(8)) sif ();

    dm_encode_ctrl #(
        .DATA_W(8), .ACC_W(ACC_W), .BITS_PER_SAMPLE(NBITS),
        .STEP_MIN(STEP_MIN), .STEP_MAX(STEP_MAX), .RUN_LEN(RUN_LEN)
    ) dut (
        .CLK100MHZ(CLK100MHZ), .CPU_RESETN(CPU_RESETN), .clear(clear),
        .step_init(step_init), .tick(tick), .s(sif.slave),
        .bit_out(bit_out), .bit_valid(bit_valid), .busy(busy),
        .step_cur(step_cur), .est(est)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    int checks = 0;
    int errors = 0;

    // Reference model: estimate/step as integers, emitted bits kept in a queue.
    int m_est;
    int m_step;
    bit m_hist[$];

    task automatic model_clear(input int st);
        m_est  = 0;
        m_step = st;
        m_hist.delete();
    endtask

    function automatic bit model_tick(input int smp);
        bit b;
        int n;
        bit same;
        b = (smp >= m_est);
        if (b) m_est = (m_est + m_step > 2**ACC_W - 1) ? 2**ACC_W - 1 : m_est + m_step;
        else   m_est = (m_est - m_step < 0) ? 0 : m_est - m_step;
`ifdef DM_ADAPT_EN
        m_hist.push_back(b);
        n = m_hist.size();
        same = (n >= RUN_LEN);
        for (int i = 1; i < RUN_LEN && same; i++)
            if (m_hist[n-1-i] != b) same = 1'b0;
        if (same)
            m_step = (2 * m_step > STEP_MAX) ? STEP_MAX : 2 * m_step;
        else if (n >= 2 && m_hist[n-2] != b)
            m_step = (m_step / 2 < STEP_MIN) ? STEP_MIN : m_step / 2;
`endif
        return b;
    endfunction

    task automatic cyc();
        @(posedge CLK100MHZ);
        #1;
    endtask

    task automatic do_clear(input logic [7:0] st);
        clear = 1'b1; step_init = st;
        cyc();
        clear = 1'b0;
        model_clear(int'(st));
    endtask

    task automatic accept(input logic [7:0] d, input string tag);
        checks++;
        if (sif.s_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_before_accept actual %b required 1", tag, sif.s_ready);
        end
        sif.s_valid = 1'b1; sif.s_data = d;
        cyc();
        sif.s_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || sif.s_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s accept actual busy=%b ready=%b required busy=1 ready=0", tag, busy, sif.s_ready);
        end
    endtask

    task automatic tick_check(input int smp, input bit last, input string tag);
        bit eb;
        eb = model_tick(smp);
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        checks++;
        if (bit_valid !== 1'b1 || bit_out !== eb || est !== ACC_W'(m_est) || step_cur !== 8'(m_step)) begin
            errors++;
            $display("FAIL %s bit actual v=%b b=%b est=%0d step=%0d required v=1 b=%b est=%0d step=%0d",
                     tag, bit_valid, bit_out, est, step_cur, eb, m_est, m_step);
        end
        checks++;
        if (busy !== !last || sif.s_ready !== last) begin
            errors++;
            $display("FAIL %s state actual busy=%b ready=%b required busy=%b ready=%b",
                     tag, busy, sif.s_ready, !last, last);
        end
    endtask

    task automatic test_reset();
        sif.s_valid = 1'b0; sif.s_data = '0;
        CPU_RESETN = 1'b0;
        cyc(); cyc();
        checks++;
        if (sif.s_ready !== 1'b1 || busy !== 1'b0 || bit_out !== 1'b0 || bit_valid !== 1'b0 ||
            step_cur !== 8'(STEP_MIN) || est !== '0) begin
            errors++;
            $display("FAIL reset actual rdy=%b busy=%b bo=%b bv=%b step=%0d est=%0d required 1 0 0 0 %0d 0",
                     sif.s_ready, busy, bit_out, bit_valid, step_cur, est, STEP_MIN);
        end
        CPU_RESETN = 1'b1;
        model_clear(STEP_MIN);
        cyc();
    endtask

    task automatic test_spec_vectors();
`ifndef DM_ADAPT_EN
        int eb[8] = '{1, 1, 1, 1, 1, 1, 0, 1};
        int ee[8] = '{4, 8, 12, 16, 20, 24, 20, 24};
        do_clear(8'd4);
        accept(8'd20, "fixed_accept");
        for (int i = 0; i < NBITS; i++) begin
            tick_check(20, i == NBITS - 1, "fixed_model");
            checks++;
            if (bit_out !== eb[i][0] || est !== ACC_W'(ee[i])) begin
                errors++;
                $display("FAIL fixed_vec[%0d] actual b=%b est=%0d required b=%0d est=%0d", i, bit_out, est, eb[i], ee[i]);
            end
        end
        checks++;
        if (step_cur !== 8'd4) begin
            errors++;
            $display("FAIL fixed_step actual %0d required 4", step_cur);
        end
`else
        int ee[8] = '{1, 2, 3, 5, 9, 17, 33, 65};
        do_clear(8'd1);
        accept(8'd200, "adapt_accept");
        for (int i = 0; i < NBITS; i++) begin
            tick_check(200, i == NBITS - 1, "adapt_model");
            checks++;
            if (bit_out !== 1'b1 || est !== ACC_W'(ee[i])) begin
                errors++;
                $display("FAIL adapt_vec[%0d] actual b=%b est=%0d required b=1 est=%0d", i, bit_out, est, ee[i]);
            end
        end
        checks++;
        if (step_cur !== 8'd64) begin
            errors++;
            $display("FAIL adapt_step_max actual %0d required 64", step_cur);
        end
        accept(8'd0, "adapt_accept0");
        tick_check(0, 1'b0, "adapt_zero1");
        checks++;
        if (bit_out !== 1'b0 || est !== ACC_W'(1) || step_cur !== 8'd32) begin
            errors++;
            $display("FAIL adapt_zero1 actual b=%b est=%0d step=%0d required b=0 est=1 step=32", bit_out, est, step_cur);
        end
        tick_check(0, 1'b0, "adapt_zero2");
        checks++;
        if (bit_out !== 1'b0 || est !== '0 || step_cur !== 8'd32) begin
            errors++;
            $display("FAIL adapt_zero2 actual b=%b est=%0d step=%0d required b=0 est=0 step=32", bit_out, est, step_cur);
        end
        for (int i = 2; i < NBITS; i++) tick_check(0, i == NBITS - 1, "adapt_zero_rest");
`endif
    endtask

    task automatic test_handshake();
        accept(8'd100, "hs_accept1");
        sif.s_valid = 1'b1; sif.s_data = 8'd20;
        for (int i = 0; i < 50; i++) begin
            cyc();
            checks++;
            if (sif.s_ready !== 1'b0 || bit_valid !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL hs_hold[%0d] actual rdy=%b bv=%b busy=%b required 0 0 1", i, sif.s_ready, bit_valid, busy);
            end
        end
        for (int i = 0; i < NBITS; i++) tick_check(100, i == NBITS - 1, "hs_first");
        cyc();
        checks++;
        if (sif.s_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL hs_second_accept actual rdy=%b busy=%b required 0 1", sif.s_ready, busy);
        end
        sif.s_valid = 1'b0;
        for (int i = 0; i < NBITS; i++) tick_check(20, i == NBITS - 1, "hs_second");
    endtask

    task automatic test_idle_tick();
        for (int i = 0; i < 3; i++) begin
            tick = 1'b1;
            cyc();
            tick = 1'b0;
            checks++;
            if (bit_valid !== 1'b0 || busy !== 1'b0 || est !== ACC_W'(m_est) || step_cur !== 8'(m_step)) begin
                errors++;
                $display("FAIL idle_tick actual bv=%b busy=%b est=%0d step=%0d required 0 0 %0d %0d",
                         bit_valid, busy, est, step_cur, m_est, m_step);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        d = 8'($urandom_range(255));
        accept(d, "rst_accept");
        for (int i = 0; i < 3; i++) tick_check(int'(d), 1'b0, "rst_pre");
        #2 CPU_RESETN = 1'b0;
        #1;
        checks++;
        if (sif.s_ready !== 1'b1 || busy !== 1'b0 || bit_out !== 1'b0 || bit_valid !== 1'b0 ||
            step_cur !== 8'(STEP_MIN) || est !== '0) begin
            errors++;
            $display("FAIL reset_mid actual rdy=%b busy=%b bo=%b bv=%b step=%0d est=%0d required 1 0 0 0 %0d 0",
                     sif.s_ready, busy, bit_out, bit_valid, step_cur, est, STEP_MIN);
        end
        cyc();
        CPU_RESETN = 1'b1;
        model_clear(STEP_MIN);
        cyc();
        d = 8'($urandom_range(255));
        accept(d, "rst_after");
        for (int i = 0; i < NBITS; i++) tick_check(int'(d), i == NBITS - 1, "rst_after_bits");
    endtask

    task automatic test_clear_tick();
        logic [7:0] d;
        logic [7:0] st;
        d  = 8'($urandom_range(255));
        st = 8'($urandom_range(STEP_MAX, 1));
        accept(d, "clr_accept");
        tick_check(int'(d), 1'b0, "clr_pre");
        tick_check(int'(d), 1'b0, "clr_pre");
        clear = 1'b1; tick = 1'b1; step_init = st;
        cyc();
        clear = 1'b0; tick = 1'b0;
        model_clear(int'(st));
        checks++;
        if (bit_valid !== 1'b0 || sif.s_ready !== 1'b1 || busy !== 1'b0 || est !== '0 || step_cur !== st) begin
            errors++;
            $display("FAIL clear_tick actual bv=%b rdy=%b busy=%b est=%0d step=%0d required 0 1 0 0 %0d",
                     bit_valid, sif.s_ready, busy, est, step_cur, st);
        end
        d = 8'($urandom_range(255));
        accept(d, "clr_after");
        for (int i = 0; i < NBITS; i++) tick_check(int'(d), i == NBITS - 1, "clr_after_bits");
    endtask

    task automatic test_random();
        logic [7:0] d;
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(4) == 0) do_clear(8'($urandom_range(STEP_MAX, 1)));
            case ($urandom_range(3))
                0: d = 8'd0;
                1: d = 8'd255;
                default: d = 8'($urandom_range(255));
            endcase
            accept(d, "rnd_accept");
            for (int i = 0; i < NBITS; i++) begin
                for (int g = $urandom_range(3); g > 0; g--) begin
                    sif.s_valid = 1'($urandom_range(1));
                    sif.s_data  = 8'($urandom_range(255));
                    cyc();
                    checks++;
                    if (bit_valid !== 1'b0 || busy !== 1'b1) begin
                        errors++;
                        $display("FAIL rnd_gap actual bv=%b busy=%b required 0 1", bit_valid, busy);
                    end
                end
                sif.s_valid = 1'b0;
                tick_check(int'(d), i == NBITS - 1, "rnd_bit");
            end
        end
    endtask

    initial begin
        test_reset();
        test_spec_vectors();
        test_handshake();
        test_idle_tick();
        test_reset_mid();
        test_clear_tick();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual timeout required completion");
        $fatal(1, "watchdog expired");
    end
endmodule
